// File: rtl/gate_exerciser.sv
// Exhaustive stimulus/response engine for a combinational gate.
// Sweeps every input vector, samples the gate, and scores it against TRUTH.
module gate_exerciser #(
  parameter int                        N_IN   = 2,
  parameter logic [(2**N_IN)-1:0]      TRUTH  = 4'b1000,
  parameter int                        SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0]    SET_CNT = 4'(SETTLE);
  localparam logic [N_IN:0] ERR_ONE = (N_IN+1)'(1);
  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic [N_IN-1:0] stim_n;
  logic            busy_n;
  logic            done_n;
  logic            pass_n;
  logic [N_IN:0]   err_n;
  logic            fv_n;
  logic [N_IN-1:0] ffv_n;
  logic            mismatch;

  assign mismatch = dut_y != TRUTH[stim_out];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      stim_out       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      stim_out       <= stim_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      err_count      <= err_n;
      fail_valid     <= fv_n;
      first_fail_vec <= ffv_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stim_n  = stim_out;
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    err_n   = err_count;
    fv_n    = fail_valid;
    ffv_n   = first_fail_vec;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          cnt_n   = SET_CNT;
          stim_n  = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          err_n   = '0;
          fv_n    = 1'b0;
          ffv_n   = '0;
        end
      end
      RUN: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          if (mismatch) begin
            err_n = err_count + ERR_ONE;
            if (!fail_valid) begin
              fv_n  = 1'b1;
              ffv_n = stim_out;
            end
          end
          // Last vector ends the sweep before the counter could wrap
          if (stim_out != '1) begin
            stim_n = stim_out + VEC_ONE;
            cnt_n  = SET_CNT;
          end else begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            stim_n  = '0;
            pass_n  = (err_n == '0);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Self-checking bench for gate_exerciser.
// Two instances: AND/SETTLE=1 and XOR/SETTLE=0, scoreboarded results.
module tb_gate_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b;
  logic       y_a, y_b;
  logic [1:0] stim_a, stim_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;
  logic       pass_a, pass_b;
  logic [2:0] err_a, err_b;
  logic       fv_a, fv_b;
  logic [1:0] ffv_a, ffv_b;

  int   mode_a, mode_b;
  logic sel;

  logic [1:0] o_stim;
  logic       o_busy, o_done, o_pass, o_fv;
  logic [2:0] o_err;
  logic [1:0] o_ffv;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int lat;
    int err;
    int ffv;
    int fv;
    int pass;
  } res_t;

  res_t res_q[$];
  int   stim_q[$];

  gate_exerciser #(
    .N_IN(2), .TRUTH(4'b1000), .SETTLE(1)
  ) u_and (
    .clk(clk), .rst(rst), .start(start_a), .dut_y(y_a),
    .stim_out(stim_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .fail_valid(fv_a),
    .first_fail_vec(ffv_a)
  );

  gate_exerciser #(
    .N_IN(2), .TRUTH(4'b0110), .SETTLE(0)
  ) u_xor (
    .clk(clk), .rst(rst), .start(start_b), .dut_y(y_b),
    .stim_out(stim_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .fail_valid(fv_b),
    .first_fail_vec(ffv_b)
  );

  // 0 = AND, 1 = stuck 0, 2 = stuck 1, 3 = XOR
  function automatic logic gate(input int m, input logic [1:0] v);
    case (m)
      0:       return v[0] & v[1];
      1:       return 1'b0;
      2:       return 1'b1;
      default: return v[0] ^ v[1];
    endcase
  endfunction

  always_comb y_a = gate(mode_a, stim_a);
  always_comb y_b = gate(mode_b, stim_b);

  always_comb begin
    o_stim = sel ? stim_b : stim_a;
    o_busy = sel ? busy_b : busy_a;
    o_done = sel ? done_b : done_a;
    o_pass = sel ? pass_b : pass_a;
    o_err  = sel ? err_b  : err_a;
    o_fv   = sel ? fv_b   : fv_a;
    o_ffv  = sel ? ffv_b  : ffv_a;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit w, input logic v);
    if (w) start_b = v;
    else   start_a = v;
  endtask

  task automatic push_expect(input bit w, input int mode, input int settle);
    logic [3:0] tt;
    res_t       r;
    tt     = w ? 4'b0110 : 4'b1000;
    r.err  = 0;
    r.fv   = 0;
    r.ffv  = 0;
    for (int v = 0; v < 4; v++) begin
      for (int s = 0; s <= settle; s++) stim_q.push_back(v);
      if (gate(mode, 2'(v)) != tt[v]) begin
        if (r.fv == 0) begin
          r.fv  = 1;
          r.ffv = v;
        end
        r.err++;
      end
    end
    r.lat  = 4 * (settle + 1);
    r.pass = (r.err == 0) ? 1 : 0;
    res_q.push_back(r);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_stim"}, o_stim, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_pass"}, o_pass, 0);
    check({tag, "_err"},  o_err,  0);
    check({tag, "_fv"},   o_fv,   0);
    check({tag, "_ffv"},  o_ffv,  0);
  endtask

  task automatic sweep(input bit w, input int mode, input bit pulse);
    int   cyc;
    int   settle;
    res_t r;
    sel    = w;
    settle = w ? 0 : 1;
    if (w) mode_b = mode;
    else   mode_a = mode;
    push_expect(w, mode, settle);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    cyc = 0;
    check("clr_err", o_err, 0);
    check("clr_done", o_done, 0);
    check("clr_fv", o_fv, 0);
    while (1) begin
      if (cyc < res_q[0].lat && stim_q.size() > 0) begin
        check("stim", o_stim, stim_q.pop_front());
        check("busy", o_busy, 1);
      end
      if (pulse) set_start(w, (cyc == 1 || cyc == 4));
      @(posedge clk); #1;
      cyc++;
      if (o_done || cyc > 64) break;
    end
    set_start(w, 1'b0);
    stim_q.delete();
    r = res_q.pop_front();
    check("latency", cyc, r.lat);
    check("err", o_err, r.err);
    check("ffv", o_ffv, r.ffv);
    check("fv", o_fv, r.fv);
    check("pass", o_pass, r.pass);
    check("end_busy", o_busy, 0);
    check("end_stim", o_stim, 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", o_done, 1);
    check("err_hold", o_err, r.err);
  endtask

  initial begin
    int cyc;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a  = 0;
    mode_b  = 3;
    sel     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sel = 1'b0;
    check_idle("rst_a");
    sel = 1'b1;
    check_idle("rst_b");

    sweep(1'b0, 0, 1'b0);
    sweep(1'b0, 1, 1'b0);
    sweep(1'b0, 2, 1'b0);
    sweep(1'b1, 3, 1'b0);
    sweep(1'b1, 0, 1'b0);

    // Reset lands on the third edge after the start edge
    sel     = 1'b0;
    mode_a  = 1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 0;
    repeat (2) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("midrst");
    repeat (12) @(posedge clk);
    #1;
    check("midrst_done", o_done, 0);
    check("midrst_busy", o_busy, 0);

    sweep(1'b0, 0, 1'b0);
    sweep(1'b0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
